// File: rtl/sw_debounce.sv
// Four-switch debouncer with clock-lock gating and a registered LED-mux select.
// Define SW_DEBOUNCE_ONEHOT_EN to force sel to zero and flag sel_err on multi-hot switch settings.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk25,
  input  logic       n_reset,
  input  logic       locked,
  input  logic [3:0] sw,
  output logic [3:0] sw_clean,
  output logic [3:0] sw_change,
  output logic [3:0] sel,
  output logic       sel_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES must be in [1, 2**CNT_W)");
  end

  logic [3:0]       sw_meta;
  logic [3:0]       sw_sync;
  logic             lock_meta;
  logic             lock_sync;
  logic [CNT_W-1:0] cnt [4];

`ifdef SW_DEBOUNCE_ONEHOT_EN
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction
`endif

  // Synchronizer stage: both async inputs are double-flopped into clk25.
  always_ff @(posedge clk25 or negedge n_reset) begin
    if (!n_reset) begin
      sw_meta   <= 4'b0000;
      sw_sync   <= 4'b0000;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  // Debounce stage: a count survives only while the synced level keeps disagreeing with sw_clean.
  always_ff @(posedge clk25 or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      sw_clean  <= 4'b0000;
      sw_change <= 4'b0000;
      sel       <= 4'b0000;
      sel_err   <= 1'b0;
    end else if (!lock_sync) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      sw_clean  <= 4'b0000;
      sw_change <= 4'b0000;
      sel       <= 4'b0000;
      sel_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sw_change[i] <= 1'b0;
        if (sw_sync[i] == sw_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_clean[i]  <= sw_sync[i];
          sw_change[i] <= 1'b1;
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // Select stage: registered from the previous sw_clean, one cycle behind it.
`ifdef SW_DEBOUNCE_ONEHOT_EN
      sel     <= is_onehot(sw_clean) ? sw_clean : 4'b0000;
      sel_err <= (sw_clean != 4'b0000) && !is_onehot(sw_clean);
`else
      sel     <= sw_clean;
      sel_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Randomized bench for sw_debounce, compared every cycle against a run-length reference model,
// plus directed checks at the edge counts the debouncer must meet.
module tb_sw_debounce;

  localparam int D = 16;

  logic       clk25 = 1'b0;
  logic       n_reset;
  logic       locked;
  logic [3:0] sw;
  logic [3:0] sw_clean;
  logic [3:0] sw_change;
  logic [3:0] sel;
  logic       sel_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sw_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clk25    (clk25),
    .n_reset  (n_reset),
    .locked   (locked),
    .sw       (sw),
    .sw_clean (sw_clean),
    .sw_change(sw_change),
    .sel      (sel),
    .sel_err  (sel_err)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen two edges late, a switch flips after D consecutive disagreeing samples.
  logic [3:0] sw_d1, sw_d2;
  logic       lk_d1, lk_d2;
  int         run [4];
  logic [3:0] m_clean, m_change, m_sel;
  logic       m_err;
  logic [3:0] old_clean;

  always @(posedge clk25) begin
    if (!n_reset) begin
      sw_d1 = '0; sw_d2 = '0; lk_d1 = 0; lk_d2 = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_clean = '0; m_change = '0; m_sel = '0; m_err = 0;
    end else begin
      old_clean = m_clean;
      if (!lk_d2) begin
        for (int i = 0; i < 4; i++) run[i] = 0;
        m_clean = '0; m_change = '0; m_sel = '0; m_err = 0;
      end else begin
        m_change = '0;
        for (int i = 0; i < 4; i++) begin
          if (sw_d2[i] != old_clean[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == D) begin
              m_clean[i]  = sw_d2[i];
              m_change[i] = 1'b1;
              run[i]      = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
`ifdef SW_DEBOUNCE_ONEHOT_EN
        m_sel = ($countones(old_clean) == 1) ? old_clean : 4'b0000;
        m_err = ($countones(old_clean) > 1);
`else
        m_sel = old_clean;
        m_err = 1'b0;
`endif
      end
      sw_d2 = sw_d1; sw_d1 = sw;
      lk_d2 = lk_d1; lk_d1 = locked;
    end
  end

  always begin
    @(posedge clk25);
    #5;
    if (chk_en) begin
      check("m_clean",  sw_clean,  m_clean);
      check("m_change", sw_change, m_change);
      check("m_sel",    sel,       m_sel);
      check("m_err",    {3'b000, sel_err}, {3'b000, m_err});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic settle(input logic [3:0] v);
    sw = v;
    edges(D + 4);
  endtask

  initial begin
    n_reset = 1'b0;
    locked  = 1'b0;
    sw      = 4'b0000;
    edges(3);
    check("rst_clean", sw_clean, 4'b0000);
    check("rst_chg",   sw_change, 4'b0000);
    check("rst_sel",   sel, 4'b0000);
    check("rst_err",   {3'b000, sel_err}, 4'b0000);
    n_reset = 1'b1;
    locked  = 1'b1;
    chk_en  = 1'b1;
    edges(5);

    // Single switch press: accepted at edge D+2, sel one edge later.
    sw = 4'b0010;
    edges(D + 1);
    check("s1_early", sw_clean, 4'b0000);
    edges(1);
    check("s1_clean", sw_clean, 4'b0010);
    check("s1_chg",   sw_change, 4'b0010);
    edges(1);
    check("s1_chg_off", sw_change, 4'b0000);
    check("s1_sel",     sel, 4'b0010);

    // Several bits changing together pulse together.
    settle(4'b0001);
    sw = 4'b0110;
    edges(D + 1);
    check("s6_early", sw_change, 4'b0000);
    edges(1);
    check("s6_chg",   sw_change, 4'b0111);
    check("s6_clean", sw_clean, 4'b0110);

    // Multi-hot setting.
    settle(4'b0000);
    sw = 4'b0101;
    edges(D + 3);
    check("s3_clean", sw_clean, 4'b0101);
`ifdef SW_DEBOUNCE_ONEHOT_EN
    check("s3_sel", sel, 4'b0000);
    check("s3_err", {3'b000, sel_err}, 4'b0001);
`else
    check("s3_sel", sel, 4'b0101);
    check("s3_err", {3'b000, sel_err}, 4'b0000);
`endif

    // Bouncing bit never accepted until it holds.
    settle(4'b0000);
    for (int k = 0; k < 20; k++) begin
      sw[0] = ~sw[0];
      for (int j = 0; j < 5; j++) begin
        edges(1);
        check("s2_bounce", sw_change, 4'b0000);
      end
    end
    sw[0] = 1'b1;
    edges(D + 1);
    check("s2_early", sw_clean, 4'b0000);
    edges(1);
    check("s2_clean", sw_clean, 4'b0001);

    // Reset mid-operation clears everything at once and restarts the count.
    settle(4'b1000);
    check("s4_pre", sw_clean, 4'b1000);
    n_reset = 1'b0;
    #1;
    check("s4_async_clean", sw_clean, 4'b0000);
    check("s4_async_sel",   sel, 4'b0000);
    edges(2);
    check("s4_hold_clean", sw_clean, 4'b0000);
    edges(1);
    n_reset = 1'b1;
    edges(D + 1);
    check("s4_early", sw_clean, 4'b0000);
    edges(1);
    check("s4_clean", sw_clean, 4'b1000);

    // Lock loss holds the datapath in reset.
    settle(4'b0100);
    edges(1);
    check("s5_pre_sel", sel, 4'b0100);
    locked = 1'b0;
    edges(3);
    check("s5_clean_off", sw_clean, 4'b0000);
    check("s5_sel_off",   sel, 4'b0000);
    edges(7);
    locked = 1'b1;
    edges(D + 1);
    check("s5_early", sw_clean, 4'b0000);
    edges(1);
    check("s5_clean", sw_clean, 4'b0100);

    // Random phases of bouncing and holding, with occasional reset and lock drops.
    for (int blk = 0; blk < 60; blk++) begin
      bit hold;
      hold = ($urandom_range(0, 1) == 1);
      sw = 4'($urandom);
      for (int c = 0; c < 40; c++) begin
        edges(1);
        if (!hold && $urandom_range(0, 3) == 0) sw = 4'($urandom);
        if ($urandom_range(0, 299) == 0) begin
          n_reset = 1'b0;
          edges($urandom_range(1, 3));
          n_reset = 1'b1;
        end
        if ($urandom_range(0, 299) == 0) begin
          locked = 1'b0;
          edges($urandom_range(1, 12));
          locked = 1'b1;
        end
      end
    end

    edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
